// File: rtl/hockey_pkg.sv
// Shared constants, auto-player state enum and small helpers for the hockey block.
package hockey_pkg;

  localparam logic [1:0] DIR_STRAIGHT = 2'b00;
  localparam logic [1:0] DIR_UP       = 2'b01;
  localparam logic [1:0] DIR_DOWN     = 2'b10;

  localparam int X_MAX = 4;
  localparam int Y_MAX = 4;

  typedef enum logic [2:0] {
    AP_IDLE,
    AP_WAIT,
    AP_PRESS,
    AP_HOLD,
    AP_COOL
  } ap_state_e;

  // Direction rotation: straight -> up -> down -> straight.
  function automatic logic [1:0] dir_next(input logic [1:0] d);
    unique case (d)
      DIR_STRAIGHT: return DIR_UP;
      DIR_UP:       return DIR_DOWN;
      default:      return DIR_STRAIGHT;
    endcase
  endfunction

  function automatic logic [2:0] y_wrap_inc(input logic [2:0] y, input logic [2:0] ymax);
    return (y >= ymax) ? 3'd0 : y + 3'd1;
  endfunction

endpackage

// File: rtl/hockey_arrival_det.sv
// Puck arrival detector: fires when the puck steps from the adjacent column onto our goal column.
module hockey_arrival_det #(
  parameter int SIDE_X = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] x_i,
  input  logic [2:0] y_i,
  output logic       arrive_o,
  output logic [2:0] y_o
);
  localparam logic [2:0] SIDE = 3'(SIDE_X);
  localparam logic [2:0] ADJ  = (SIDE_X == 0) ? 3'd1 : 3'(SIDE_X - 1);

  logic [2:0] prev_x_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_x_q <= SIDE;
    else      prev_x_q <= x_i;
  end

  assign arrive_o = (x_i == SIDE) && (prev_x_q == ADJ);
  assign y_o      = y_i;

endmodule

// File: rtl/hockey_auto_player.sv
// Automated hockey opponent: serves on request and returns arriving pucks.
// Optional deliberate-miss behaviour enabled by defining HOCKEY_AUTO_MISS_EN.
module hockey_auto_player #(
  parameter int SIDE_X      = 4,
  parameter int Y_MAX       = 4,
  parameter int SERVE_DELAY = 3,
  parameter int REACT_DELAY = 1,
  parameter int BTN_LEN     = 1,
  parameter int MISS_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       serve_turn,
  input  logic [2:0] X_COORD,
  input  logic [2:0] Y_COORD,
  output logic       BTN,
  output logic [1:0] DIR,
  output logic [2:0] Y_in,
  output logic       busy
);
  import hockey_pkg::*;

  ap_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] y_q, y_d;
  logic [1:0] dir_q, dir_d;
  logic [2:0] serve_y_q, serve_y_d;
  logic [1:0] dir_seq_q, dir_seq_d;
  logic       is_serve_q, is_serve_d;
  logic       btn_q, busy_q;
  logic       arrive;
  logic [2:0] arr_y;
`ifdef HOCKEY_AUTO_MISS_EN
  logic [7:0] miss_q, miss_d;
`endif

  hockey_arrival_det #(.SIDE_X(SIDE_X)) u_arr (
    .clk      (clk),
    .rst      (rst),
    .x_i      (X_COORD),
    .y_i      (Y_COORD),
    .arrive_o (arrive),
    .y_o      (arr_y)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    dir_d      = dir_q;
    serve_y_d  = serve_y_q;
    dir_seq_d  = dir_seq_q;
    is_serve_d = is_serve_q;
`ifdef HOCKEY_AUTO_MISS_EN
    miss_d     = miss_q;
`endif
    unique case (state_q)
      AP_IDLE: begin
        // Serve has priority; a coincident arrival is dropped.
        if (enable && serve_turn) begin
          state_d    = AP_WAIT;
          cnt_d      = 8'(SERVE_DELAY);
          y_d        = serve_y_q;
          dir_d      = dir_seq_q;
          is_serve_d = 1'b1;
        end else if (enable && arrive) begin
          state_d    = AP_WAIT;
          cnt_d      = 8'(REACT_DELAY);
          dir_d      = dir_seq_q;
          is_serve_d = 1'b0;
`ifdef HOCKEY_AUTO_MISS_EN
          if (miss_q == 8'(MISS_PERIOD - 1)) begin
            y_d    = y_wrap_inc(arr_y, 3'(Y_MAX));
            miss_d = '0;
          end else begin
            y_d    = arr_y;
            miss_d = miss_q + 8'd1;
          end
`else
          y_d        = arr_y;
`endif
        end
      end
      AP_WAIT: begin
        if (cnt_q == '0) begin
          state_d = AP_PRESS;
          cnt_d   = 8'(BTN_LEN - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      AP_PRESS: begin
        if (cnt_q == '0) state_d = AP_HOLD;
        else             cnt_d   = cnt_q - 8'd1;
      end
      AP_HOLD: begin
        // Press complete: release paddle/direction and advance the sequences.
        state_d   = AP_COOL;
        cnt_d     = 8'd1;
        y_d       = '0;
        dir_d     = DIR_STRAIGHT;
        dir_seq_d = dir_next(dir_seq_q);
        if (is_serve_q) serve_y_d = y_wrap_inc(serve_y_q, 3'(Y_MAX));
      end
      AP_COOL: begin
        if (cnt_q == '0) state_d = AP_IDLE;
        else             cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = AP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= AP_IDLE;
      cnt_q      <= '0;
      y_q        <= '0;
      dir_q      <= DIR_STRAIGHT;
      serve_y_q  <= 3'd2;
      dir_seq_q  <= DIR_STRAIGHT;
      is_serve_q <= 1'b0;
      btn_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef HOCKEY_AUTO_MISS_EN
      miss_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      serve_y_q  <= serve_y_d;
      dir_seq_q  <= dir_seq_d;
      is_serve_q <= is_serve_d;
      btn_q      <= (state_d == AP_PRESS);
      busy_q     <= (state_d != AP_IDLE);
`ifdef HOCKEY_AUTO_MISS_EN
      miss_q     <= miss_d;
`endif
    end
  end

  assign BTN  = btn_q;
  assign DIR  = dir_q;
  assign Y_in = y_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_hockey_auto_player.sv
// Bench for hockey_auto_player: timeline-based reference model plus directed and random stimulus.
module tb_hockey_auto_player;
  localparam int SD = 3, RD = 1, BL = 1, MP = 4;

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, serve_turn = 1'b0;
  logic [2:0] X_COORD = 3'd0, Y_COORD = 3'd0;
  logic       BTN, busy;
  logic [1:0] DIR;
  logic [2:0] Y_in;

  int nvec = 0, nerr = 0, cyc = 0;
  int npress = 0, last_y = 0, last_dir = 0, p0 = 0;
  int exp_y[4];

  // Model: one press "episode" described by start edge, delay and latched values.
  int m_prev_x, m_serve_y, m_dirseq, m_miss, m_t0, m_d, m_y, m_dirv, m_free;
  bit m_has;

  hockey_auto_player #(
    .SIDE_X(4), .Y_MAX(4), .SERVE_DELAY(SD), .REACT_DELAY(RD), .BTN_LEN(BL), .MISS_PERIOD(MP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .serve_turn(serve_turn),
    .X_COORD(X_COORD), .Y_COORD(Y_COORD),
    .BTN(BTN), .DIR(DIR), .Y_in(Y_in), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_x = 4; m_serve_y = 2; m_dirseq = 0; m_miss = 0;
    m_has = 0; m_t0 = 0; m_d = 0; m_y = 0; m_dirv = 0; m_free = 0;
  endtask

  task automatic model_edge();
    bit arrive;
    int d, y;
    cyc++;
    if (!rst) return;
    arrive   = (int'(X_COORD) == 4) && (m_prev_x == 3);
    m_prev_x = int'(X_COORD);
    if (enable && cyc >= m_free && (serve_turn || arrive)) begin
      if (serve_turn) begin
        d = SD; y = m_serve_y;
        m_serve_y = (m_serve_y + 1) % 5;
      end else begin
        d = RD; y = int'(Y_COORD);
`ifdef HOCKEY_AUTO_MISS_EN
        m_miss++;
        if (m_miss == MP) begin m_miss = 0; y = (y + 1) % 5; end
`endif
      end
      m_has = 1; m_t0 = cyc; m_d = d; m_y = y; m_dirv = m_dirseq;
      m_dirseq = (m_dirseq + 1) % 3;
      m_free = cyc + d + BL + 5;
    end
  endtask

  task automatic cmp_model();
    int k;
    bit hold;
    k    = cyc - m_t0;
    hold = m_has && (k <= m_d + BL + 1);
    chk("busy", int'(busy), int'(m_has && k < m_d + BL + 4));
    chk("BTN",  int'(BTN),  int'(m_has && k >= m_d + 1 && k <= m_d + BL));
    chk("Y_in", int'(Y_in), hold ? m_y : 0);
    chk("DIR",  int'(DIR),  hold ? m_dirv : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
    if (BTN === 1'b1) begin npress++; last_y = int'(Y_in); last_dir = int'(DIR); end
  endtask

  initial begin
`ifdef HOCKEY_AUTO_MISS_EN
    exp_y[0] = 4; exp_y[1] = 4; exp_y[2] = 4; exp_y[3] = 0;
`else
    exp_y[0] = 4; exp_y[1] = 4; exp_y[2] = 4; exp_y[3] = 4;
`endif
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_btn", int'(BTN), 0); chk("rst_dir", int'(DIR), 0);
    chk("rst_y", int'(Y_in), 0);  chk("rst_busy", int'(busy), 0);
    step(); step();
    rst = 1'b1; enable = 1'b1;
    step();

    // First serve: press at E+4 with Y=2, DIR=straight.
    serve_turn = 1'b1; step(); serve_turn = 1'b0;
    repeat (3) step();
    chk("srv1_early", int'(BTN), 0);
    step();
    chk("srv1_btn", int'(BTN), 1); chk("srv1_y", int'(Y_in), 2); chk("srv1_dir", int'(DIR), 0);
    step();
    chk("srv1_len", int'(BTN), 0);
    repeat (6) step();

    // Second serve advances both sequences.
    serve_turn = 1'b1; step(); serve_turn = 1'b0;
    repeat (4) step();
    chk("srv2_btn", int'(BTN), 1); chk("srv2_y", int'(Y_in), 3); chk("srv2_dir", int'(DIR), 1);
    repeat (7) step();

    // Return: 3 -> 4 with Y=2 presses two edges after arrival.
    X_COORD = 3'd3; Y_COORD = 3'd2; step();
    X_COORD = 3'd4; step();
    step();
    chk("ret_early", int'(BTN), 0);
    step();
    chk("ret_btn", int'(BTN), 1); chk("ret_y", int'(Y_in), 2); chk("ret_dir", int'(DIR), 2);
    p0 = npress;
    repeat (10) step();
    chk("no_retrig_44", npress - p0, 0);
    chk("ret_busy_lo", int'(busy), 0);

    // Serve and arrival on the same edge: one press with serve values.
    X_COORD = 3'd3; step();
    X_COORD = 3'd4; serve_turn = 1'b1; p0 = npress; step(); serve_turn = 1'b0;
    repeat (12) step();
    chk("simul_cnt", npress - p0, 1); chk("simul_y", last_y, 4); chk("simul_dir", last_dir, 0);
    chk("simul_busy", int'(busy), 0);

    // Disabled: nothing presses.
    enable = 1'b0; p0 = npress;
    repeat (40) begin
      X_COORD = 3'($urandom_range(0, 4)); Y_COORD = 3'($urandom_range(0, 4));
      serve_turn = 1'($urandom_range(0, 1));
      step();
    end
    chk("dis_nopress", npress - p0, 0);
    serve_turn = 1'b0; X_COORD = 3'd0; enable = 1'b1;
    step(); step();

    // Enable dropped during WAIT: press still completes; serve_y wrapped to 0.
    serve_turn = 1'b1; p0 = npress; step(); serve_turn = 1'b0; enable = 1'b0;
    repeat (3) step();
    step();
    chk("endrop_btn", int'(BTN), 1); chk("endrop_y", int'(Y_in), 0);
    repeat (8) step();
    chk("endrop_cnt", npress - p0, 1); chk("endrop_busy", int'(busy), 0);
    enable = 1'b1;

    // Reset asserted mid-press clears BTN without a clock edge.
    serve_turn = 1'b1; step(); serve_turn = 1'b0;
    repeat (4) step();
    chk("rst_pre_btn", int'(BTN), 1);
    rst = 1'b0; #1;
    model_reset();
    chk("rstmid_btn", int'(BTN), 0); chk("rstmid_busy", int'(busy), 0);
    step();
    rst = 1'b1;
    step();
    chk("rstrel_y", int'(Y_in), 0); chk("rstrel_dir", int'(DIR), 0);

    // Four returns at the top row.
    for (int i = 0; i < 4; i++) begin
      X_COORD = 3'd3; Y_COORD = 3'd4; step();
      X_COORD = 3'd4; p0 = npress; step();
      repeat (9) step();
      chk("miss_cnt", npress - p0, 1);
      chk("miss_y", last_y, exp_y[i]);
    end

    // Randomized play against the model, with occasional async resets.
    repeat (1500) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0; #1; model_reset();
      end else begin
        rst = 1'b1;
      end
      enable     = ($urandom_range(0, 15) != 0);
      serve_turn = ($urandom_range(0, 9) == 0);
      X_COORD    = 3'($urandom_range(0, 4));
      Y_COORD    = 3'($urandom_range(0, 4));
      step();
    end
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
